// File: rtl/fetch_sequencer.sv
// Instruction fetch/issue unit: drives the synchronous imem read port and presents instructions.
// Define INSTR_COUNT_EN to add the retired_count output and its counter.
module fetch_sequencer #(
   parameter int unsigned ADDR_W  = 10,
   parameter int unsigned INSTR_W = 24
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               stall,
   input  logic               pc_src,
   input  logic [ADDR_W-1:0]  branch_target,
   input  logic               finish,
   output logic               imem_rd,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic               instr_valid,
   output logic [ADDR_W-1:0]  pc,
   output logic               busy,
   output logic               done
`ifdef INSTR_COUNT_EN
   ,
   output logic [31:0]        retired_count
`endif
);

   typedef enum logic [1:0] {StIdle, StFill, StRun, StHalt} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    fpc_q, fpc_d;
   logic [ADDR_W-1:0]    ipc_q, ipc_d;
   logic                 pend_q, pend_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic                 valid_q, valid_d;
   logic                 done_q, done_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         fpc_q   <= '0;
         ipc_q   <= '0;
         pend_q  <= 1'b0;
         instr_q <= '0;
         pc_q    <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         ipc_q   <= ipc_d;
         pend_q  <= pend_d;
         instr_q <= instr_d;
         pc_q    <= pc_d;
         valid_q <= valid_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      ipc_d   = ipc_q;
      pend_d  = pend_q;
      instr_d = instr_q;
      pc_d    = pc_q;
      valid_d = valid_q;
      done_d  = done_q;
      imem_rd = 1'b0;
      case (state_q)
         StIdle, StHalt: begin
            if (start) begin
               state_d = StFill;
               fpc_d   = '0;
               done_d  = 1'b0;
            end
         end
         StFill, StRun: begin
            if (!stall) begin
               if (valid_q && finish) begin
                  state_d = StHalt;
                  pend_d  = 1'b0;
                  valid_d = 1'b0;
                  done_d  = 1'b1;
               end else if (valid_q && pc_src) begin
                  // Drop the in-flight fetch; the target is issued next cycle.
                  fpc_d   = branch_target;
                  pend_d  = 1'b0;
                  valid_d = 1'b0;
               end else begin
                  imem_rd = 1'b1;
                  ipc_d   = fpc_q;
                  fpc_d   = fpc_q + ADDR_W'(1);
                  pend_d  = 1'b1;
                  state_d = StRun;
                  if (state_q == StRun) begin
                     if (pend_q) begin
                        instr_d = imem_data;
                        pc_d    = ipc_q;
                        valid_d = 1'b1;
                     end else begin
                        valid_d = 1'b0;
                     end
                  end
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign imem_addr   = fpc_q;
   assign instr       = instr_q;
   assign opcode      = instr_q[INSTR_W-1 -: 6];
   assign instr_valid = valid_q;
   assign pc          = pc_q;
   assign busy        = (state_q == StFill) || (state_q == StRun);
   assign done        = done_q;

`ifdef INSTR_COUNT_EN
   logic [31:0] cnt_q;
   logic        start_acc;
   logic        retire;

   assign start_acc = start && ((state_q == StIdle) || (state_q == StHalt));
   assign retire    = busy && !stall && valid_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (start_acc) begin
         cnt_q <= '0;
      end else if (retire) begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign retired_count = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus random traffic against a queue-based model.
module tb_fetch_sequencer;
   localparam int AW  = 10;
   localparam int IW  = 24;
   localparam int N   = 1024;
   localparam int SAW = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset;
   logic          start, stall, pc_src, finish;
   logic [AW-1:0] branch_target;
   logic          imem_rd;
   logic [AW-1:0] imem_addr;
   logic [IW-1:0] imem_data;
   logic [IW-1:0] instr;
   logic [5:0]    opcode;
   logic          instr_valid;
   logic [AW-1:0] pc;
   logic          busy, done;

   logic           start_s;
   logic           s_imem_rd;
   logic [SAW-1:0] s_imem_addr;
   logic [IW-1:0]  s_imem_data;
   logic [IW-1:0]  s_instr;
   logic [5:0]     s_opcode;
   logic           s_instr_valid;
   logic [SAW-1:0] s_pc;
   logic           s_busy, s_done;
`ifdef INSTR_COUNT_EN
   logic [31:0]    retired_count;
   logic [31:0]    s_retired_count;
`endif

   fetch_sequencer #(.ADDR_W(AW), .INSTR_W(IW)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .stall         (stall),
      .pc_src        (pc_src),
      .branch_target (branch_target),
      .finish        (finish),
      .imem_rd       (imem_rd),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .instr         (instr),
      .opcode        (opcode),
      .instr_valid   (instr_valid),
      .pc            (pc),
      .busy          (busy),
      .done          (done)
`ifdef INSTR_COUNT_EN
      ,
      .retired_count (retired_count)
`endif
   );

   fetch_sequencer #(.ADDR_W(SAW), .INSTR_W(IW)) dut_s (
      .clk           (clk),
      .reset         (reset),
      .start         (start_s),
      .stall         (1'b0),
      .pc_src        (1'b0),
      .branch_target ('0),
      .finish        (1'b0),
      .imem_rd       (s_imem_rd),
      .imem_addr     (s_imem_addr),
      .imem_data     (s_imem_data),
      .instr         (s_instr),
      .opcode        (s_opcode),
      .instr_valid   (s_instr_valid),
      .pc            (s_pc),
      .busy          (s_busy),
      .done          (s_done)
`ifdef INSTR_COUNT_EN
      ,
      .retired_count (s_retired_count)
`endif
   );

   logic [IW-1:0] mem [N];

   always @(posedge clk) if (imem_rd) imem_data <= mem[int'(imem_addr)];
   always @(posedge clk) if (s_imem_rd) s_imem_data <= mem[int'(s_imem_addr)];

   // Reference model: running/done flags, next fetch address, queue of in-flight fetches.
   bit          m_run, m_done, m_valid;
   int          m_next, m_pc;
   logic [IW-1:0] m_instr;
   logic [31:0] m_cnt;
   int          q[$];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_done = 0; m_valid = 0;
      m_next = 0; m_pc = 0; m_instr = '0; m_cnt = '0;
      q.delete();
   endtask

   task automatic check_regs();
      chk("instr_valid", 32'(instr_valid), 32'(m_valid));
      chk("pc", 32'(pc), 32'(m_pc));
      chk("instr", 32'(instr), 32'(m_instr));
      chk("opcode", 32'(opcode), 32'(m_instr[IW-1 -: 6]));
      chk("busy", 32'(busy), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
`ifdef INSTR_COUNT_EN
      chk("retired_count", retired_count, m_cnt);
`endif
   endtask

   // Called while clk is low; drives inputs, checks the read port, advances one edge.
   task automatic step(input bit st, input bit ps, input bit fn, input bit sta, input int tgt);
      bit exp_rd;
      stall = st; pc_src = ps; finish = fn; start = sta; branch_target = tgt[AW-1:0];
      #1;
      exp_rd = m_run && !st && !(m_valid && (fn || ps));
      chk("imem_rd", 32'(imem_rd), 32'(exp_rd));
      if (exp_rd) chk("imem_addr", 32'(imem_addr), 32'(m_next));
      @(posedge clk);
      if (!m_run) begin
         if (sta) begin
            m_run = 1; m_done = 0; m_next = 0; m_cnt = '0;
            q.delete();
         end
      end else if (!st) begin
         if (m_valid) m_cnt = m_cnt + 32'd1;
         if (m_valid && fn) begin
            m_run = 0; m_done = 1; m_valid = 0;
            q.delete();
         end else if (m_valid && ps) begin
            m_valid = 0; m_next = tgt % N;
            q.delete();
         end else begin
            if (q.size() > 0) begin
               m_pc = q.pop_front();
               m_instr = mem[m_pc];
               m_valid = 1;
            end else begin
               m_valid = 0;
            end
            q.push_back(m_next);
            m_next = (m_next + 1) % N;
         end
      end
      #1;
      check_regs();
      @(negedge clk);
      stall = 0; pc_src = 0; finish = 0; start = 0;
   endtask

   task automatic run_until(input int addr);
      for (int i = 0; i < 64; i++) begin
         if (m_valid && m_pc == addr) break;
         step(0, 0, 0, 0, 0);
      end
      chk("reach_pc", 32'(pc), 32'(addr));
   endtask

   task automatic finish_prog();
      for (int i = 0; i < 8; i++) begin
         if (!m_run) break;
         step(0, 0, m_valid, 0, 0);
      end
      chk("halted_done", 32'(done), 32'd1);
      chk("halted_busy", 32'(busy), 32'd0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < N; i++) mem[i] = IW'($urandom);
      for (int i = 0; i < 4; i++) mem[i] = IW'(i + 1);
      reset = 1'b1; start = 0; stall = 0; pc_src = 0; finish = 0; branch_target = '0;
      start_s = 0;
      model_reset();
      #1 reset = 1'b0;
      #2;
      check_regs();
      chk("rst_imem_rd", 32'(imem_rd), 32'd0);
      chk("rst_imem_addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // Straight line: valid from edge 2, pc 0..3, halt on finish at pc 3.
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      chk("sl_edge1_invalid", 32'(instr_valid), 32'd0);
      step(0, 0, 0, 0, 0);
      chk("sl_edge2_valid", 32'(instr_valid), 32'd1);
      chk("sl_pc0_instr", 32'(instr), 32'h1);
      for (int i = 0; i < 8; i++) begin
         if (!m_run) break;
         step(0, 0, m_valid && m_pc == 3, 0, 0);
      end
      chk("sl_done", 32'(done), 32'd1);
      chk("sl_last_instr", 32'(instr), 32'h4);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Branch at pc 2 to 0x010: two bubbles, then target.
      step(0, 0, 0, 1, 0);
      run_until(2);
      step(0, 1, 0, 0, 16);
      chk("br_bubble1", 32'(instr_valid), 32'd0);
      step(0, 0, 0, 0, 0);
      chk("br_bubble2", 32'(instr_valid), 32'd0);
      step(0, 0, 0, 0, 0);
      chk("br_target_pc", 32'(pc), 32'h10);
      chk("br_target_instr", 32'(instr), 32'(mem[16]));
      finish_prog();

      // Stall for 3 cycles at pc 5; branch/finish during stall ignored.
      step(0, 0, 0, 1, 0);
      run_until(5);
      step(1, 0, 0, 0, 0);
      step(1, 1, 1, 0, 33);
      step(1, 0, 0, 0, 0);
      chk("st_pc_held", 32'(pc), 32'd5);
      step(0, 0, 0, 0, 0);
      chk("st_next_pc", 32'(pc), 32'd6);
      finish_prog();

      // Finish and branch together: finish wins.
      step(0, 0, 0, 1, 0);
      run_until(1);
      step(0, 1, 1, 0, 40);
      chk("sim_done", 32'(done), 32'd1);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);

      // Asynchronous reset mid-run at pc 7.
      step(0, 0, 0, 1, 0);
      run_until(7);
      #2 reset = 1'b0;
      #1;
      model_reset();
      check_regs();
      chk("mid_rst_imem_rd", 32'(imem_rd), 32'd0);
      chk("mid_rst_imem_addr", 32'(imem_addr), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("mid_rst_refetch_pc", 32'(pc), 32'd0);
      chk("mid_rst_refetch_valid", 32'(instr_valid), 32'd1);
      finish_prog();

      // Wrap on the ADDR_W=4 instance: pc runs 0..15, 0..3.
      k = 0;
      start_s = 1;
      step(0, 0, 0, 0, 0);
      start_s = 0;
      for (int i = 0; i < 21; i++) begin
         step(0, 0, 0, 0, 0);
         if (s_instr_valid) begin
            chk("wrap_pc", 32'(s_pc), 32'(k % 16));
            chk("wrap_instr", 32'(s_instr), 32'(mem[k % 16]));
            k++;
         end
      end
      chk("wrap_count", 32'(k), 32'd20);

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 24) == 0, !m_run && ($urandom_range(0, 2) == 0),
              int'($urandom_range(0, N - 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
